// File: rtl/i2c_target_stretch_if.sv
// i2c_target_stretch_if: I2C target pins plus received-byte valid/ready stream
// slave modport: the target (drives line enables and rx stream); master modport: the bus/consumer side
interface i2c_target_stretch_if;
  logic       scl_i;
  logic       sda_i;
  logic       scl_oe;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;
  logic       stretching;
  logic       overrun;
  modport slave (
    input  scl_i, sda_i, rx_ready,
    output scl_oe, sda_oe, rx_data, rx_valid, busy, stretching, overrun
  );
  modport master (
    output scl_i, sda_i, rx_ready,
    input  scl_oe, sda_oe, rx_data, rx_valid, busy, stretching, overrun
  );
endinterface

// File: rtl/i2c_target_stretch.sv
// i2c_target_stretch: write-only I2C target with ACK, valid/ready byte output and optional clock stretching
// Ports: clk, rst (sync, active-low); bus.slave: scl_i/sda_i raw lines in, scl_oe/sda_oe pull-low enables,
//   rx_data/rx_valid/rx_ready byte stream, busy (START..STOP), stretching (=scl_oe), overrun (sticky).
// Build option: define I2C_TGT_STRETCH_EN to hold SCL low after each byte until it is consumed.
module i2c_target_stretch #(
  parameter logic [6:0]  ADDR    = 7'h42,
  parameter logic [15:0] TIMEOUT = 16'd24000
) (
  input logic              clk,
  input logic              rst,
  i2c_target_stretch_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_HOLD, S_DATA_ACK, S_IGNORE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  scl_q, scl_d, sda_q, sda_d, cnt_q, cnt_d;
  logic [7:0]  sr_q, sr_d, rx_data_q, rx_data_d;
  logic [15:0] tmo_q, tmo_d;
  logic        done_q, done_d, scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
  logic        rx_valid_q, rx_valid_d, overrun_q, overrun_d;
  logic        scl_rise, scl_fall, start, stop, hs, hit;
  // [1] is the synchronized level, [2] its previous value for edge detection
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = ~sda_q[1] & sda_q[2] & scl_q[1];
  assign stop     = sda_q[1] & ~sda_q[2] & scl_q[1];
  assign hs       = rx_valid_q & bus.rx_ready;
  assign hit      = sr_q == {ADDR, 1'b0};
  always_comb begin
    scl_d      = {scl_q[1:0], bus.scl_i};
    sda_d      = {sda_q[1:0], bus.sda_i};
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    done_d     = done_q;
    tmo_d      = 16'd0;
    scl_oe_d   = scl_oe_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~hs;
    overrun_d  = overrun_q;
    if (scl_rise && (state_q == S_ADDR || state_q == S_RX)) begin
      sr_d   = {sr_q[6:0], sda_q[1]};
      cnt_d  = cnt_q + 3'd1;
      done_d = cnt_q == 3'd7;
    end
    case (state_q)
      S_ADDR: if (scl_fall && done_q) begin
        done_d   = 1'b0;
        sda_oe_d = hit;
        state_d  = hit ? S_ADDR_ACK : S_IGNORE;
      end
      S_ADDR_ACK, S_DATA_ACK: if (scl_fall) begin
        sda_oe_d = 1'b0;
        state_d  = S_RX;
      end
      S_RX: if (scl_fall && done_q) begin
        done_d = 1'b0;
        if (rx_valid_q) begin
          // previous byte still unconsumed: NACK and drop this one
          overrun_d = 1'b1;
          state_d   = S_DATA_ACK;
        end else begin
          rx_data_d  = sr_q;
          rx_valid_d = 1'b1;
`ifdef I2C_TGT_STRETCH_EN
          scl_oe_d   = 1'b1;
          state_d    = S_HOLD;
`else
          sda_oe_d   = 1'b1;
          state_d    = S_DATA_ACK;
`endif
        end
      end
      S_HOLD: begin
        // ACK goes out one cycle after the handshake, SCL is released the cycle after that
        tmo_d = tmo_q + 16'd1;
        if (sda_oe_q) begin
          scl_oe_d = 1'b0;
          state_d  = S_DATA_ACK;
        end else if (hs) begin
          sda_oe_d = 1'b1;
        end else if (tmo_q == TIMEOUT - 16'd1) begin
          scl_oe_d = 1'b0;
          state_d  = S_IGNORE;
        end
      end
      default: ;
    endcase
    if (stop) begin
      state_d  = S_IDLE;
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
    end else if (start) begin
      state_d  = S_ADDR;
      cnt_d    = 3'd0;
      done_d   = 1'b0;
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state_q    <= S_IDLE;
      scl_q      <= 3'b111;
      sda_q      <= 3'b111;
      cnt_q      <= 3'd0;
      sr_q       <= 8'h00;
      done_q     <= 1'b0;
      tmo_q      <= 16'd0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  assign bus.scl_oe     = scl_oe_q;
  assign bus.stretching = scl_oe_q;
  assign bus.sda_oe     = sda_oe_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = state_q != S_IDLE;
endmodule

// File: tb/tb_i2c_target_stretch.sv
// tb_i2c_target_stretch: scoreboard bench driving an open-drain I2C master model into the target
module tb_i2c_target_stretch;
  localparam int Q = 10;
  localparam int H = 20;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic ack_probe = 1'b0;
  logic pv = 1'b0;
  logic pr = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int st_bad = 0;
  int scl_hi_seen = 0;
  logic [7:0] data_q[$];
  logic ack_q[$];
  i2c_target_stretch_if bus();
  i2c_target_stretch #(.ADDR(7'h42), .TIMEOUT(16'd2000)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.scl_i = scl_m & ~bus.scl_oe;
  assign bus.sda_i = sda_m & ~bus.sda_oe;
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      if (bus.stretching !== bus.scl_oe) st_bad++;
      if (bus.scl_oe) scl_hi_seen++;
      if (bus.rx_valid && !pv) begin
        if (data_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rx_unexpected: got byte %0h, want no byte", bus.rx_data);
        end else check("rx_data", bus.rx_data, data_q.pop_front());
      end
      if (pv && pr) check("rx_valid_clear", bus.rx_valid, 0);
      if (ack_probe) begin
        if (ack_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ack_unexpected: got probe, want none");
        end else check("ack", bus.sda_oe, ack_q.pop_front());
      end
    end
    pv <= bus.rx_valid;
    pr <= bus.rx_ready;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_scl();
    int w = 0;
    while (!bus.scl_i && w < 6000) begin
      tick(1);
      w++;
    end
    if (!bus.scl_i) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scl_release: got low, want high within 6000 cycles");
    end
  endtask
  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(H);
    sda_m = 1'b0; tick(H);
    scl_m = 1'b0; tick(Q);
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(H);
    sda_m = 1'b1; tick(H);
  endtask
  task automatic send_bit(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1'b1; wait_scl(); tick(H);
    scl_m = 1'b0; tick(Q);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; wait_scl(); tick(H / 2);
    ack_q.push_back(ack);
    ack_probe = 1'b1; tick(1);
    ack_probe = 1'b0; tick(H / 2);
    scl_m = 1'b0; tick(Q);
  endtask
  task automatic reset_vals(input string tag);
    check({tag, "_scl_oe"}, bus.scl_oe, 0);
    check({tag, "_sda_oe"}, bus.sda_oe, 0);
    check({tag, "_rx_data"}, bus.rx_data, 0);
    check({tag, "_rx_valid"}, bus.rx_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_stretching"}, bus.stretching, 0);
    check({tag, "_overrun"}, bus.overrun, 0);
  endtask
  task automatic wait_valid();
    int w = 0;
    while (!bus.rx_valid && w < 3000) begin
      tick(1);
      w++;
    end
    check("rx_valid_rise", bus.rx_valid, 1);
  endtask
  initial begin
    int held;
    bus.rx_ready = 1'b1;
    tick(3);
    reset_vals("reset");
    rst = 1'b1;
    tick(5);
    i2c_start();
    check("busy_start", bus.busy, 1);
    send_byte(8'h84, 1'b1);
    data_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    i2c_stop(); tick(4);
    check("busy_stop", bus.busy, 0);
    check("rx_data_a5", bus.rx_data, 8'hA5);
    check("rx_valid_a5", bus.rx_valid, 0);
    i2c_start();
    send_byte(8'h86, 1'b0);
    send_byte(8'hFF, 1'b0);
    check("busy_ignore", bus.busy, 1);
    i2c_stop(); tick(4);
    check("busy_ignore_stop", bus.busy, 0);
    i2c_start();
    send_byte(8'h85, 1'b0);
    i2c_stop(); tick(4);
    check("rx_valid_nack", bus.rx_valid, 0);
    check("rx_data_kept", bus.rx_data, 8'hA5);
    i2c_start();
    send_byte(8'h84, 1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    i2c_start();
    send_byte(8'h84, 1'b1);
    data_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    i2c_stop(); tick(4);
    check("rx_data_5a", bus.rx_data, 8'h5A);
`ifdef I2C_TGT_STRETCH_EN
    bus.rx_ready = 1'b0;
    i2c_start();
    send_byte(8'h84, 1'b1);
    data_q.push_back(8'h3C);
    fork
      send_byte(8'h3C, 1'b1);
      begin
        wait_valid();
        check("hold_scl_oe_rise", bus.scl_oe, 1);
        held = 0;
        repeat (500) begin
          tick(1);
          if (bus.scl_oe) held++;
        end
        check("stretch_500", held, 500);
        bus.rx_ready = 1'b1; tick(1);
        check("hs_n1_sda_oe", bus.sda_oe, 1);
        check("hs_n1_scl_oe", bus.scl_oe, 1);
        tick(1);
        check("hs_n2_scl_oe", bus.scl_oe, 0);
      end
    join
    i2c_stop(); tick(4);
    check("busy_3c", bus.busy, 0);
    bus.rx_ready = 1'b0;
    i2c_start();
    send_byte(8'h84, 1'b1);
    data_q.push_back(8'h77);
    fork
      send_byte(8'h77, 1'b0);
      begin
        wait_valid();
        held = 0;
        while (bus.scl_oe && held < 5000) begin
          held++;
          tick(1);
        end
        check("timeout_len", held, 2000);
      end
    join
    check("timeout_busy", bus.busy, 1);
    check("timeout_rx_valid", bus.rx_valid, 1);
    send_byte(8'h99, 1'b0);
    i2c_stop(); tick(4);
    check("timeout_stop_busy", bus.busy, 0);
    check("timeout_stop_valid", bus.rx_valid, 1);
    bus.rx_ready = 1'b1; tick(3);
    check("timeout_consumed", bus.rx_valid, 0);
    bus.rx_ready = 1'b0;
    i2c_start();
    send_byte(8'h84, 1'b1);
    data_q.push_back(8'hC3);
    fork
      send_byte(8'hC3, 1'b0);
      begin
        wait_valid();
        tick(50);
        check("hold_before_rst", bus.scl_oe, 1);
        rst = 1'b0; tick(1);
        reset_vals("hold_rst");
        rst = 1'b1;
      end
    join
    i2c_stop(); tick(4);
    check("busy_after_rst", bus.busy, 0);
`else
    bus.rx_ready = 1'b0;
    i2c_start();
    send_byte(8'h84, 1'b1);
    data_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    check("overrun_pre", bus.overrun, 0);
    send_byte(8'h22, 1'b0);
    check("overrun_set", bus.overrun, 1);
    check("overrun_rx_data", bus.rx_data, 8'h11);
    check("overrun_rx_valid", bus.rx_valid, 1);
    i2c_stop(); tick(4);
    check("overrun_busy", bus.busy, 0);
    bus.rx_ready = 1'b1; tick(3);
    check("overrun_consumed", bus.rx_valid, 0);
    check("overrun_sticky", bus.overrun, 1);
    check("scl_oe_never", scl_hi_seen, 0);
`endif
    tick(5);
    check("data_q_empty", data_q.size(), 0);
    check("ack_q_empty", ack_q.size(), 0);
    check("stretching_eq_scl_oe", st_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, want finish before 90000 cycles");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/i2c_target_stretch.md
I2C_TARGET_STRETCH -- requirements
Module: i2c_target_stretch

Interface
REQ-001 Parameter: ADDR, 7'h42, 7-bit target address matched against the address byte.
REQ-002 Parameter: TIMEOUT, 16'd24000, maximum clk cycles SCL may be held low by stretching.
REQ-003 Port: clk  input  1  system clock; all logic on posedge clk.
REQ-004 Port: rst  input  1  reset; synchronous and active-low.
REQ-005 Port: scl_i  input  1  raw SCL line level.
REQ-006 Port: sda_i  input  1  raw SDA line level.
REQ-007 Port: scl_oe  output  1  1 = pull SCL low (stretch); 0 = release.
REQ-008 Port: sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
REQ-009 Port: rx_data  output  8  last received data byte.
REQ-010 Port: rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-011 Port: rx_ready  input  1  consumer accepts rx_data when rx_valid=1.
REQ-012 Port: busy  output  1  1 from START until STOP.
REQ-013 Port: stretching  output  1  1 while scl_oe=1.
REQ-014 Port: overrun  output  1  sticky; a byte arrived while rx_valid=1.

Function
REQ-015 scl_i and sda_i SHALL pass through 2-flop synchronizers; edge detection uses a third registered copy.
REQ-016 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while synced SCL high.
REQ-017 States: IDLE, ADDR, ADDR_ACK, RX, HOLD, DATA_ACK, IGNORE.
REQ-018 IDLE -> ADDR on START; START in any other state (repeated START) -> ADDR with the bit counter cleared.
REQ-019 STOP in any state -> IDLE next cycle with scl_oe=0, sda_oe=0; rx_valid and rx_data are unaffected.
REQ-020 Bits SHALL be sampled on the SCL rising edge, MSB first; a 3-bit counter counts 0..7.
REQ-021 ADDR: on the SCL falling edge after bit 8, if byte[7:1]==ADDR and byte[0]==0 -> ADDR_ACK with sda_oe=1; otherwise -> IGNORE with sda_oe=0.
REQ-022 ADDR_ACK/DATA_ACK: sda_oe SHALL stay 1 through the 9th SCL high and clear on the following SCL falling edge; the state then -> RX.
REQ-023 RX: on the SCL falling edge after bit 8, rx_data is loaded and rx_valid=1 in the same cycle.
REQ-024 Handshake: rx_valid clears on the cycle after any cycle with rx_valid=1 and rx_ready=1.
REQ-025 IGNORE: sda_oe=0 and scl_oe=0; leave only on START or STOP.
REQ-026 Reads (R/W=1) are not supported and are NACKed per REQ-021.
REQ-027 If a byte completes while rx_valid=1, overrun=1 and that byte is NACKed and discarded; overrun clears only on reset.
REQ-028 stretching SHALL equal scl_oe at all times.

Reset
REQ-029 With rst=0 at a clock edge: state=IDLE; scl_oe=0, sda_oe=0, rx_data=8'h00, rx_valid=0, busy=0, stretching=0, overrun=0; synchronizers are loaded with 1.
REQ-030 Reset mid-transfer SHALL release both lines on the next edge; the partial byte is discarded.

Configuration
REQ-031 Macro I2C_TGT_STRETCH_EN defined: RX completion -> HOLD with scl_oe=1 from the same cycle rx_valid rises.
REQ-032 In HOLD, the handshake cycle N sets sda_oe=1 at N+1 and scl_oe=0 at N+2; the state then -> DATA_ACK. REQ-027 cannot trigger in this configuration.
REQ-033 In HOLD, after TIMEOUT cycles: scl_oe=0, the byte is NACKed, and the state -> IGNORE; rx_valid remains set.
REQ-034 Macro undefined: HOLD is absent, scl_oe is constant 0, and RX completion -> DATA_ACK directly (ACK unless REQ-027 applies).

Verification
REQ-035 START, address 0x84 (0x42 write), data 0xA5, rx_ready held 1, STOP -> both ACKs seen; rx_data=0xA5; rx_valid pulses for one cycle; busy 1->0.
REQ-036 Address 0x86 -> no ACK (sda_oe=0 on 9th clock); rx_valid never rises; IGNORE until STOP.
REQ-037 STRETCH_EN, rx_ready=0 for 500 cycles after byte 0x3C -> scl_oe=1 for >=500 cycles; rx_ready=1 at cycle N -> sda_oe=1 at N+1, scl_oe=0 at N+2.
REQ-038 STRETCH_EN undefined, two bytes 0x11 and 0x22 with rx_ready=0 -> 0x11 ACKed, 0x22 NACKed; overrun=1; rx_data=0x11.
REQ-039 Repeated START after 3 data bits, then address 0x84 and data 0x5A -> counter restarts; rx_data=0x5A.
REQ-040 rst=0 during HOLD -> scl_oe=0 and state IDLE on the next edge; all outputs at reset values.
